id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus execute-side operand select. Registers decoded fields from ID each cycle.

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage_fwd_unit.sv | 18 +
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the ID/EX stage: operand-select encodings,
// forwarding-source selector, EX control bundle and ALU opcodes.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 5;

    // Encoding 3 of either select falls back to the register operand.
    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ex_ctrl_t;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [CTRL_W-1:0] ALU_AND  = 5'd2;
    localparam logic [CTRL_W-1:0] ALU_OR   = 5'd3;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 5'd9;

    // MEM is the younger producer, so it beats WB; x0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] mem_rd,
        input logic            mem_we,
        input logic [RA_W-1:0] wb_rd,
        input logic            wb_we
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != '0 && mem_we && mem_rd == rs) begin
            sel = FWD_MEM;
        end else if (rs != '0 && wb_we && wb_rd == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX stage, later pipeline stages and the ALU.
interface id_ex_stage_if;
    import riscv_pkg::*;

    // Handshake: id_valid marks a real instruction in ID; there is no ready wire.
    // load_use_stall is the inverse of ready: while it is high ID must hold and
    // re-present the same instruction, and EX receives a bubble instead.
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [RA_W-1:0]   id_rd;
    logic [1:0]        id_a_sel;
    logic [1:0]        id_b_sel;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_branch;
    logic              id_jump;
    logic              flush;

    logic [RA_W-1:0]   mem_rd;
    logic [RA_W-1:0]   wb_rd;
    logic              mem_reg_write;
    logic              wb_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_result;

    logic              load_use_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ALU_A;
    logic [XLEN-1:0]   ALU_B;
    logic [CTRL_W-1:0] ALU_control;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_jump;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_a_sel, id_b_sel, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jump, flush,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result, wb_result,
        input  load_use_stall, ex_valid, ALU_A, ALU_B, ALU_control, ex_store_data, ex_pc,
               ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_a_sel, id_b_sel, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               id_branch, id_jump, flush,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result, wb_result,
        output load_use_stall, ex_valid, ALU_A, ALU_B, ALU_control, ex_store_data, ex_pc,
               ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational forwarding selector for the two EX source operands.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    output fwd_sel_t        fwd_a,
    output fwd_sel_t        fwd_b
);

    assign fwd_a = fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    assign fwd_b = fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, MEM/WB forwarding and
// ALU operand selection feeding the execute stage.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    id_ex_stage_if.slave bus
);

    logic              ex_valid_q, ex_valid_d;
    ex_ctrl_t          ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
    logic [RA_W-1:0]   ex_rs1_q, ex_rs1_d;
    logic [RA_W-1:0]   ex_rs2_q, ex_rs2_d;
    logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
    logic [1:0]        ex_a_sel_q, ex_a_sel_d;
    logic [1:0]        ex_b_sel_q, ex_b_sel_d;
    logic [CTRL_W-1:0] ex_alu_ctrl_q, ex_alu_ctrl_d;

    logic              load_use_stall;
    fwd_sel_t          fwd_a, fwd_b;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
    logic [XLEN-1:0]   alu_a, alu_b;

    // A load in EX cannot supply its value until MEM, so a dependent ID instruction waits one cycle.
    assign load_use_stall = ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != '0) & bus.id_valid &
                            ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));

    always_comb begin
        ex_valid_d         = bus.id_valid;
        ex_ctrl_d          = '0;
        ex_ctrl_d.reg_write = bus.id_reg_write;
        ex_ctrl_d.mem_read  = bus.id_mem_read;
        ex_ctrl_d.mem_write = bus.id_mem_write;
        ex_ctrl_d.branch    = bus.id_branch;
        ex_ctrl_d.jump      = bus.id_jump;
        ex_pc_d            = bus.id_pc;
        ex_imm_d           = bus.id_imm;
        ex_rs1_data_d      = bus.id_rs1_data;
        ex_rs2_data_d      = bus.id_rs2_data;
        ex_rs1_d           = bus.id_rs1;
        ex_rs2_d           = bus.id_rs2;
        ex_rd_d            = bus.id_rd;
        ex_a_sel_d         = bus.id_a_sel;
        ex_b_sel_d         = bus.id_b_sel;
        ex_alu_ctrl_d      = bus.id_alu_ctrl;
        // Bubbles only clear valid and control; data fields load regardless.
        if (bus.flush || load_use_stall) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_a_sel_q    <= '0;
            ex_b_sel_q    <= '0;
            ex_alu_ctrl_q <= ALU_ADD;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_a_sel_q    <= ex_a_sel_d;
            ex_b_sel_q    <= ex_b_sel_d;
            ex_alu_ctrl_q <= ex_alu_ctrl_d;
        end
    end

    fwd_unit u_fwd (
        .ex_rs1        (ex_rs1_q),
        .ex_rs2        (ex_rs2_q),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    always_comb begin
        fwd_rs1 = ex_rs1_data_q;
        case (fwd_a)
            FWD_MEM: fwd_rs1 = bus.mem_result;
            FWD_WB:  fwd_rs1 = bus.wb_result;
            default: ;
        endcase
        fwd_rs2 = ex_rs2_data_q;
        case (fwd_b)
            FWD_MEM: fwd_rs2 = bus.mem_result;
            FWD_WB:  fwd_rs2 = bus.wb_result;
            default: ;
        endcase
        alu_a = fwd_rs1;
        case (ex_a_sel_q)
            A_PC:    alu_a = ex_pc_q;
            A_ZERO:  alu_a = '0;
            default: ;
        endcase
        alu_b = fwd_rs2;
        case (ex_b_sel_q)
            B_IMM:   alu_b = ex_imm_q;
            B_FOUR:  alu_b = XLEN'(4);
            default: ;
        endcase
    end

    assign bus.load_use_stall = load_use_stall;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ALU_A          = alu_a;
    assign bus.ALU_B          = alu_b;
    assign bus.ALU_control    = ex_alu_ctrl_q;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.ex_reg_write   = ex_valid_q & ex_ctrl_q.reg_write;
    assign bus.ex_mem_read    = ex_valid_q & ex_ctrl_q.mem_read;
    assign bus.ex_mem_write   = ex_valid_q & ex_ctrl_q.mem_write;
    assign bus.ex_branch      = ex_valid_q & ex_ctrl_q.branch;
    assign bus.ex_jump        = ex_valid_q & ex_ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios plus a random stream.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int EXP_W = 176;
    localparam logic [EXP_W-1:0] CTRL_MASK = {6'h3f, 170'd0};
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_RW    = 5'b10000;
    localparam logic [4:0] C_LOAD  = 5'b11000;
    localparam logic [4:0] C_STORE = 5'b00100;
    localparam logic [4:0] C_BR    = 5'b00010;
    localparam logic [4:0] C_JAL   = 5'b10001;

    logic CLK = 1'b0;
    logic RESET;
    int   vectors = 0;
    int   miscompares = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] got, e;

    always #10 CLK = ~CLK;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    function automatic logic [EXP_W-1:0] pack_exp(
        input logic v, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] alu, input logic [31:0] sd, input logic [31:0] pc,
        input logic [31:0] imm, input logic [4:0] rd);
        return {v, c, a, b, alu, sd, pc, imm, rd};
    endfunction

    function automatic logic [EXP_W-1:0] dut_vec();
        return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch,
                bus.ex_jump, bus.ALU_A, bus.ALU_B, bus.ALU_control, bus.ex_store_data, bus.ex_pc,
                bus.ex_imm, bus.ex_rd};
    endfunction

    function automatic logic [31:0] ref_fwd(
        input logic [4:0] rs, input logic [31:0] rf, input logic [4:0] mrd, input logic mwe,
        input logic [31:0] mres, input logic [4:0] wrd, input logic wwe, input logic [31:0] wres);
        if (rs != 5'd0 && mwe && mrd == rs) return mres;
        if (rs != 5'd0 && wwe && wrd == rs) return wres;
        return rf;
    endfunction

    task automatic drive_id(
        input logic v, input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [1:0] as, input logic [1:0] bs, input logic [4:0] alu, input logic [4:0] ctrl,
        input logic fl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1_data = rs1d;
        bus.id_rs2_data = rs2d;
        bus.id_imm      = imm;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_a_sel    = as;
        bus.id_b_sel    = bs;
        bus.id_alu_ctrl = alu;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump} = ctrl;
        bus.flush       = fl;
    endtask

    task automatic drive_fwd(
        input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
        input logic [4:0] wrd, input logic wwe, input logic [31:0] wres);
        bus.mem_rd        = mrd;
        bus.mem_reg_write = mwe;
        bus.mem_result    = mres;
        bus.wb_rd         = wrd;
        bus.wb_reg_write  = wwe;
        bus.wb_result     = wres;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, ALU_ADD, C_NONE, 1'b0);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_id();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        #15;
        exp_q.push_back(pack_exp(1'b0, C_NONE, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0));
        got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset_state got=%h exp=%h", got, e); end
        vectors++;
        if (bus.load_use_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall got=%b exp=0", bus.load_use_stall);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_mem_priority();
        @(negedge CLK);
        drive_id(1'b1, 32'h40, 32'hAAAA, 32'h5, 32'h0, 5'd3, 5'd2, 5'd4, 2'd0, 2'd0, ALU_ADD, C_RW, 1'b0);
        tick();
        drive_fwd(5'd3, 1'b1, 32'h11, 5'd3, 1'b1, 32'h22);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h11, 32'h5, ALU_ADD, 32'h5, 32'h40, 32'h0, 5'd4));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL mem_beats_wb got=%h exp=%h", got, e); end
        drive_fwd(5'd3, 1'b0, 32'h11, 5'd3, 1'b1, 32'h22);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h22, 32'h5, ALU_ADD, 32'h5, 32'h40, 32'h0, 5'd4));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL wb_fwd_a got=%h exp=%h", got, e); end
        drive_fwd(5'd2, 1'b1, 32'h33, 5'd3, 1'b1, 32'h22);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h22, 32'h33, ALU_ADD, 32'h33, 32'h40, 32'h0, 5'd4));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL mem_fwd_b got=%h exp=%h", got, e); end
        drive_fwd(5'd9, 1'b1, 32'h33, 5'd2, 1'b1, 32'h44);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'hAAAA, 32'h44, ALU_ADD, 32'h44, 32'h40, 32'h0, 5'd4));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL wb_fwd_b got=%h exp=%h", got, e); end
    endtask

    task automatic test_x0();
        @(negedge CLK);
        drive_id(1'b1, 32'h44, 32'h0, 32'h7, 32'h0, 5'd0, 5'd0, 5'd8, 2'd0, 2'd0, ALU_ADD, C_RW, 1'b0);
        tick();
        drive_fwd(5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h0, 32'h7, ALU_ADD, 32'h7, 32'h44, 32'h0, 5'd8));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL x0_no_fwd got=%h exp=%h", got, e); end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        drive_id(1'b1, 32'h80, 32'h100, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 2'd0, 2'd1, ALU_ADD, C_LOAD, 1'b0);
        tick();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        exp_q.push_back(pack_exp(1'b1, C_LOAD, 32'h100, 32'h8, ALU_ADD, 32'h0, 32'h80, 32'h8, 5'd5));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL lw_in_ex got=%h exp=%h", got, e); end
        @(negedge CLK);
        drive_id(1'b1, 32'h84, 32'h0, 32'h9, 32'h0, 5'd5, 5'd1, 5'd6, 2'd0, 2'd0, ALU_ADD, C_RW, 1'b0);
        #1; vectors++;
        if (bus.load_use_stall !== 1'b1) begin
            miscompares++; $display("FAIL load_use_stall got=%b exp=1", bus.load_use_stall);
        end
        tick();
        drive_fwd(5'd5, 1'b1, 32'h108, 5'd0, 1'b0, 32'd0);
        exp_q.push_back('0);
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if ((got & CTRL_MASK) !== (e & CTRL_MASK)) begin
            miscompares++; $display("FAIL stall_bubble got=%h exp=%h", got & CTRL_MASK, e & CTRL_MASK);
        end
        vectors++;
        if (bus.load_use_stall !== 1'b0) begin
            miscompares++; $display("FAIL stall_released got=%b exp=0", bus.load_use_stall);
        end
        tick();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd5, 1'b1, 32'h77);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h77, 32'h9, ALU_ADD, 32'h9, 32'h84, 32'h0, 5'd6));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL add_after_stall got=%h exp=%h", got, e); end
        // A load into x0 never stalls.
        @(negedge CLK);
        drive_id(1'b1, 32'h88, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 2'd0, 2'd1, ALU_ADD, C_LOAD, 1'b0);
        tick();
        @(negedge CLK);
        drive_id(1'b1, 32'h8C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 2'd0, 2'd0, ALU_ADD, C_RW, 1'b0);
        #1; vectors++;
        if (bus.load_use_stall !== 1'b0) begin
            miscompares++; $display("FAIL lw_x0_no_stall got=%b exp=0", bus.load_use_stall);
        end
    endtask

    task automatic test_flush_stall();
        @(negedge CLK);
        drive_id(1'b1, 32'h90, 32'h200, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 2'd0, 2'd1, ALU_ADD, C_LOAD, 1'b0);
        tick();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge CLK);
        drive_id(1'b1, 32'h94, 32'h1, 32'h2, 32'h10, 5'd7, 5'd5, 5'd0, 2'd0, 2'd0, ALU_SUB, C_BR, 1'b1);
        #1; vectors++;
        if (bus.load_use_stall !== 1'b1) begin
            miscompares++; $display("FAIL rs2_stall got=%b exp=1", bus.load_use_stall);
        end
        tick();
        exp_q.push_back('0);
        got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if ((got & CTRL_MASK) !== (e & CTRL_MASK)) begin
            miscompares++; $display("FAIL flush_and_stall got=%h exp=%h", got & CTRL_MASK, e & CTRL_MASK);
        end
        @(negedge CLK);
        drive_id(1'b1, 32'h98, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 2'd1, 2'd2, ALU_ADD, C_JAL, 1'b1);
        tick();
        exp_q.push_back('0);
        got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if ((got & CTRL_MASK) !== (e & CTRL_MASK)) begin
            miscompares++; $display("FAIL flush_only got=%h exp=%h", got & CTRL_MASK, e & CTRL_MASK);
        end
    endtask

    task automatic test_jal_sel();
        @(negedge CLK);
        drive_id(1'b1, 32'h100, 32'h1234, 32'h5678, 32'h40, 5'd0, 5'd0, 5'd1, 2'd1, 2'd2, ALU_ADD, C_JAL, 1'b0);
        tick();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        exp_q.push_back(pack_exp(1'b1, C_JAL, 32'h100, 32'h4, ALU_ADD, 32'h5678, 32'h100, 32'h40, 5'd1));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL jal_link got=%h exp=%h", got, e); end
        @(negedge CLK);
        drive_id(1'b1, 32'h104, 32'h1234, 32'h5678, 32'hABCDE000, 5'd0, 5'd0, 5'd2, 2'd2, 2'd1, ALU_ADD, C_RW, 1'b0);
        tick();
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h0, 32'hABCDE000, ALU_ADD, 32'h5678, 32'h104, 32'hABCDE000, 5'd2));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL lui_zero got=%h exp=%h", got, e); end
        @(negedge CLK);
        drive_id(1'b1, 32'h108, 32'h1111, 32'h2222, 32'h3, 5'd10, 5'd11, 5'd12, 2'd3, 2'd3, ALU_XOR, C_RW, 1'b0);
        tick();
        drive_fwd(5'd11, 1'b1, 32'h5555, 5'd0, 1'b0, 32'd0);
        exp_q.push_back(pack_exp(1'b1, C_RW, 32'h1111, 32'h5555, ALU_XOR, 32'h5555, 32'h108, 32'h3, 5'd12));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL sel3_regs got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive_id(1'b1, 32'h200, 32'h1000, 32'hCAFE, 32'h4, 5'd2, 5'd3, 5'd0, 2'd0, 2'd1, ALU_ADD, C_STORE, 1'b0);
        tick();
        drive_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        exp_q.push_back(pack_exp(1'b1, C_STORE, 32'h1000, 32'h4, ALU_ADD, 32'hCAFE, 32'h200, 32'h4, 5'd0));
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL store_in_ex got=%h exp=%h", got, e); end
        #2 RESET = 1'b1;
        exp_q.push_back('0);
        #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", got, e); end
        @(negedge CLK);
        RESET = 1'b0;
        idle_id();
        tick();
        vectors++;
        if (bus.ex_mem_write !== 1'b0 || bus.ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_killed got=%b%b exp=00", bus.ex_valid, bus.ex_mem_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, r1d, r2d, imm, mres, wres, fa, fb, ea, eb;
        logic [4:0]  rs1, rs2, rd, alu, ctrl, mrd, wrd, ec;
        logic [1:0]  as, bs;
        logic        v, fl, mwe, wwe, ev;
        for (int i = 0; i < 32; i++) begin
            pc   = $urandom; r1d = $urandom; r2d = $urandom; imm = $urandom;
            mres = $urandom; wres = $urandom;
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            rd   = 5'($urandom_range(0, 31));
            alu  = 5'($urandom_range(0, 9));
            as   = 2'($urandom_range(0, 3));
            bs   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ctrl = C_RW;
                1:       ctrl = C_STORE;
                2:       ctrl = C_BR;
                3:       ctrl = C_JAL;
                default: ctrl = C_NONE;
            endcase
            v    = ($urandom_range(0, 5) != 0);
            fl   = ($urandom_range(0, 6) == 0);
            mrd  = 5'($urandom_range(0, 7));
            wrd  = 5'($urandom_range(0, 7));
            mwe  = 1'($urandom_range(0, 1));
            wwe  = 1'($urandom_range(0, 1));
            @(negedge CLK);
            drive_id(v, pc, r1d, r2d, imm, rs1, rs2, rd, as, bs, alu, ctrl, fl);
            ev = v & ~fl;
            ec = ev ? ctrl : C_NONE;
            fa = ref_fwd(rs1, r1d, mrd, mwe, mres, wrd, wwe, wres);
            fb = ref_fwd(rs2, r2d, mrd, mwe, mres, wrd, wwe, wres);
            ea = (as == 2'd1) ? pc : (as == 2'd2) ? 32'd0 : fa;
            eb = (bs == 2'd1) ? imm : (bs == 2'd2) ? 32'd4 : fb;
            exp_q.push_back(pack_exp(ev, ec, ea, eb, alu, fb, pc, imm, rd));
            tick();
            drive_fwd(mrd, mwe, mres, wrd, wwe, wres);
            #1; got = dut_vec(); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++; $display("FAIL random_%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_priority();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_jal_sel();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
